pipe_stage_buf: RTL

- Parametrised, elastic successor of the fixed 32+32-bit FI_ID stage register. Carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake.
- A 2-entry main+skid buffer gives full throughput with a registered-capacity ready. Adds synchronous flush and a saturating stall-cycle counter.
- Instantiated at IF/ID, and reusable at ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_stage_buf.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: elastic buffer state encoding and IF/ID payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_e;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int IFID_W = PC_W + INST_W;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping. Shared by performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values and no ordering race exists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic 2-entry (main+skid) pipeline stage with flush and stall counter.
// Optional: define PIPE_ZERO_BUBBLE_EN to drive out_data to zero while out_valid is low.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = IFID_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_en, skid_en;
    logic              in_fire, out_fire;
    logic              stall_inc;

    // Ready comes from registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        main_d  = in_data;
        skid_d  = in_data;
        main_en = 1'b0;
        skid_en = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    main_en = 1'b1;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect kills everything held and discards any same-cycle capture.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    // NOTE: payload registers are reset too, so out_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (main_en) main_q <= main_d;
            if (skid_en) skid_q <= skid_d;
        end
    end

`ifdef PIPE_ZERO_BUBBLE_EN
    assign out_data = out_valid ? main_q : '0;
`else
    assign out_data = main_q;
`endif

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

endmodule
